// File: rtl/mac_pkg.sv
// Shared FP16 field constants, FSM encoding and helpers for the MAC accumulation stage.
package mac_pkg;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int SIG_W = MAN_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX      = 5'h1F;
    localparam logic [15:0]      FP16_MAXNORM = 16'h7BFF;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_FP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        FP_ALIGN,
        FP_NORM,
        ACC_FP,
        HOLD
    } state_t;

    // Operands after compare/align, handed from the first to the second adder stage.
    typedef struct packed {
        logic             ovf;
        logic             sign;
        logic             sub;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig_l;
        logic [SIG_W-1:0] sig_s;
    } fp_align_t;

    function automatic logic [15:0] fp_sat(input logic sign);
        return {sign, FP16_MAXNORM[14:0]};
    endfunction
endpackage

// File: rtl/mac_accumulator_if.sv
// Product stream in, result out: the handshake bundle around the accumulation stage.
interface mac_accumulator_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_error;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_error;
    logic [CNT_W-1:0] out_count;

    modport master (
        output mode, in_valid, in_data, in_error, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_error, out_count
    );

    modport slave (
        input  mode, in_valid, in_data, in_error, in_last, out_ready,
        output in_ready, out_valid, out_data, out_error, out_count
    );
endinterface

// File: rtl/mac_accumulator_fp16_add_2stage.sv
// Two-cycle FP16 adder: registered compare/align, then combinational add/normalize/saturate.
module fp16_add_2stage
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum,
    output logic        o_ovf
);
    fp_align_t r_s1;
    fp_align_t w_s1;

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [SIG_W-1:0] w_siga, w_sigb;
    logic [14:0]      w_ka, w_kb;
    logic [SIG_W:0]   w_sum;

    assign w_ea   = i_a[14:10];
    assign w_eb   = i_b[14:10];
    // exp==0 is zero: hidden bit dropped and mantissa ignored when ranking operands.
    assign w_siga = (w_ea == '0) ? '0 : {1'b1, i_a[MAN_W-1:0]};
    assign w_sigb = (w_eb == '0) ? '0 : {1'b1, i_b[MAN_W-1:0]};
    assign w_ka   = (w_ea == '0) ? '0 : i_a[14:0];
    assign w_kb   = (w_eb == '0) ? '0 : i_b[14:0];

    always_comb begin
        logic [EXP_W-1:0] diff;
        w_s1     = '0;
        diff     = '0;
        w_s1.ovf = (w_ea == EXP_MAX) || (w_eb == EXP_MAX);
        w_s1.sub = i_a[15] ^ i_b[15];
        if (w_s1.ovf) begin
            w_s1.sign = (w_eb == EXP_MAX) ? i_b[15] : i_a[15];
        end else if (w_ka >= w_kb) begin
            diff       = w_ea - w_eb;
            w_s1.sign  = i_a[15];
            w_s1.exp   = w_ea;
            w_s1.sig_l = w_siga;
            w_s1.sig_s = (diff >= 5'd12) ? '0 : (w_sigb >> diff);
        end else begin
            diff       = w_eb - w_ea;
            w_s1.sign  = i_b[15];
            w_s1.exp   = w_eb;
            w_s1.sig_l = w_sigb;
            w_s1.sig_s = (diff >= 5'd12) ? '0 : (w_siga >> diff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_s1 <= '0;
        else if (i_en) r_s1 <= w_s1;
    end

    // sig_l >= aligned sig_s always holds, so the difference never goes negative.
    assign w_sum = r_s1.sub ? ({1'b0, r_s1.sig_l} - {1'b0, r_s1.sig_s})
                            : ({1'b0, r_s1.sig_l} + {1'b0, r_s1.sig_s});

    always_comb begin
        logic [3:0]        msb;
        logic [3:0]        lz;
        logic signed [6:0] e;
        logic [MAN_W-1:0]  m;
        o_sum = '0;
        o_ovf = 1'b0;
        msb   = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (w_sum[i]) msb = 4'(i);
        end
        lz = 4'(SIG_W - 1) - msb;
        e  = '0;
        m  = '0;
        if (r_s1.ovf) begin
            o_sum = fp_sat(r_s1.sign);
            o_ovf = 1'b1;
        end else if (w_sum[SIG_W]) begin
            e = $signed({2'b00, r_s1.exp}) + 7'sd1;
            if (e >= $signed({2'b00, EXP_MAX})) begin
                o_sum = fp_sat(r_s1.sign);
                o_ovf = 1'b1;
            end else begin
                o_sum = {r_s1.sign, e[EXP_W-1:0], w_sum[MAN_W:1]};
            end
        end else if (w_sum != '0) begin
            e = $signed({2'b00, r_s1.exp}) - $signed({3'b000, lz});
            m = MAN_W'(w_sum[SIG_W-1:0] << lz);
            if (e > 7'sd0) o_sum = {r_s1.sign, e[EXP_W-1:0], m};
        end
    end
endmodule

// File: rtl/mac_accumulator.sv
// Per-burst accumulator for the multiplier product stream (INT16 saturating or FP16).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    mac_accumulator_if.slave bus
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state;
    logic             r_mode;
    logic             r_last;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_fp_b;

    logic             w_accept;
    logic             w_first;
    logic             w_mode;
    logic             w_err_base;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_int_sum;
    logic [ACC_W-1:0] w_int_nx;
    logic             w_int_ovf;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [15:0]      w_fp_sum;
    logic             w_fp_ovf;

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_first    = (r_state == IDLE);
    assign w_mode     = w_first ? bus.mode : r_mode;
    // The first beat of a burst starts from a cleared accumulator, error and count.
    assign w_acc_base = w_first ? '0 : r_acc;
    assign w_err_base = w_first ? 1'b0 : r_err;
    assign w_cnt_base = w_first ? '0 : r_cnt;
    assign w_cnt_nx   = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);

    assign w_ext      = {{(ACC_W-16){bus.in_data[15]}}, bus.in_data};
    assign w_int_sum  = w_acc_base + w_ext;
    assign w_int_ovf  = (w_acc_base[ACC_W-1] == w_ext[ACC_W-1]) &&
                        (w_int_sum[ACC_W-1] != w_acc_base[ACC_W-1]);
    assign w_int_nx   = !w_int_ovf ? w_int_sum : (w_acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX);

    fp16_add_2stage u_fp_add (
        .clk   (clk),
        .rst   (rst),
        .i_en  (r_state == FP_ALIGN),
        .i_a   (r_acc[15:0]),
        .i_b   (r_fp_b),
        .o_sum (w_fp_sum),
        .o_ovf (w_fp_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_INT;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_fp_b      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACC, ACC_FP: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_nx;
                        if (w_first) r_mode <= bus.mode;
                        if (w_mode == MODE_FP) begin
                            if (w_first) r_acc <= '0;
                            r_err      <= w_err_base | bus.in_error;
                            r_fp_b     <= bus.in_data;
                            r_last     <= bus.in_last;
                            r_in_ready <= 1'b0;
                            r_state    <= FP_ALIGN;
                        end else begin
                            r_acc <= w_int_nx;
                            r_err <= w_err_base | bus.in_error | w_int_ovf;
                            if (bus.in_last) begin
                                r_in_ready  <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_state     <= HOLD;
                            end else begin
                                r_state <= ACC;
                            end
                        end
                    end
                end
                FP_ALIGN: r_state <= FP_NORM;
                FP_NORM: begin
                    r_acc <= ACC_W'(w_fp_sum);
                    r_err <= r_err | w_fp_ovf;
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ACC_FP;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_acc;
    assign bus.out_error = r_err;
    assign bus.out_count = r_cnt;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: a wide and a minimum-width instance driven by one stream.
module tb_mac_accumulator;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_accumulator_if #(.ACC_W(32), .CNT_W(8)) bus  ();
    mac_accumulator_if #(.ACC_W(17), .CNT_W(3)) bus2 ();

    mac_accumulator #(.ACC_W(32), .CNT_W(8)) dut   (.clk(clk), .rst(rst), .bus(bus));
    mac_accumulator #(.ACC_W(17), .CNT_W(3)) dut_n (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.mode      = bus.mode;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.in_error  = bus.in_error;
    assign bus2.in_last   = bus.in_last;
    assign bus2.out_ready = bus.out_ready;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] bd[$];
    bit          be[$];
    logic [63:0] obs_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // FP16 add as stated: flush exp==0, exp==31 saturates, truncating alignment.
    function automatic void fp_ref(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output bit ovf);
        int ea, eb, ka, kb, sga, sgb, el, ml, ms, m, e, d;
        bit sl, sub;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ovf = 1'b0;
        r = 16'h0000;
        if (ea == 31 || eb == 31) begin
            ovf = 1'b1;
            r = {(eb == 31) ? b[15] : a[15], 15'h7BFF};
            return;
        end
        ka  = (ea == 0) ? 0 : int'(a[14:0]);
        kb  = (eb == 0) ? 0 : int'(b[14:0]);
        sga = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        sgb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        sub = a[15] ^ b[15];
        if (ka >= kb) begin
            sl = a[15]; el = ea; ml = sga; ms = sgb; d = ea - eb;
        end else begin
            sl = b[15]; el = eb; ml = sgb; ms = sga; d = eb - ea;
        end
        ms = (d >= 12) ? 0 : (ms >> d);
        m  = sub ? ml - ms : ml + ms;
        e  = el;
        if (m == 0) return;
        if (m >= 2048) begin
            m = m >> 1;
            e = e + 1;
            if (e >= 31) begin
                ovf = 1'b1;
                r = {sl, 15'h7BFF};
                return;
            end
        end
        while (m < 1024) begin
            m = m << 1;
            e = e - 1;
        end
        if (e <= 0) return;
        r = {sl, 5'(e), 10'(m)};
    endfunction

    function automatic void model(input bit m, input int w, input int cw,
                                  output logic [63:0] data, output bit err, output int cnt);
        longint      acc, lo, hi;
        logic [15:0] fa, r;
        bit          o;
        int          n;
        lo  = -(longint'(1) << (w - 1));
        hi  = (longint'(1) << (w - 1)) - 1;
        acc = 0;
        fa  = 16'h0000;
        err = 1'b0;
        n   = bd.size();
        for (int i = 0; i < n; i++) begin
            err |= be[i];
            if (m == MODE_INT) begin
                acc = acc + longint'($signed(bd[i]));
                if (acc > hi) begin acc = hi; err = 1'b1; end
                if (acc < lo) begin acc = lo; err = 1'b1; end
            end else begin
                fp_ref(fa, bd[i], r, o);
                fa = r;
                err |= o;
            end
        end
        cnt  = (n > (1 << cw) - 1) ? (1 << cw) - 1 : n;
        data = (m == MODE_FP) ? 64'(fa) : (64'(acc) & ((64'd1 << w) - 64'd1));
    endfunction

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic push(input logic [15:0] d, input bit e, input bit l, input bit m,
                        output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_error = e;
        bus.in_last  = l;
        bus.mode     = m;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_error = 1'b0;
    endtask

    task automatic do_burst(input bit m, input string tag);
        int          n, w, lat, xc;
        logic [63:0] xd;
        bit          xe;
        n = bd.size();
        for (int i = 0; i < n; i++) begin
            // mode only counts on the first beat; later beats carry noise
            push(bd[i], be[i], i == n - 1, (i == 0) ? m : 1'($urandom), w);
            check({tag, ".gap"}, 64'(w), (m == MODE_FP && i > 0) ? 64'd2 : 64'd0);
        end
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), (m == MODE_FP) ? 64'd2 : 64'd0);
        obs_data = 64'(bus.out_data);
        model(m, 32, 8, xd, xe, xc);
        check({tag, ".data"},  64'(bus.out_data),  xd);
        check({tag, ".err"},   64'(bus.out_error), 64'(xe));
        check({tag, ".cnt"},   64'(bus.out_count), 64'(xc));
        model(m, 17, 3, xd, xe, xc);
        check({tag, ".data17"}, 64'(bus2.out_data),  xd);
        check({tag, ".err17"},  64'(bus2.out_error), 64'(xe));
        check({tag, ".cnt3"},   64'(bus2.out_count), 64'(xc));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".idle"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ov"},  64'(bus.out_valid), 64'd0);
        check({tag, ".ir"},  64'(bus.in_ready),  64'd1);
        check({tag, ".od"},  64'(bus.out_data),  64'd0);
        check({tag, ".oe"},  64'(bus.out_error), 64'd0);
        check({tag, ".oc"},  64'(bus.out_count), 64'd0);
    endtask

    initial begin
        int w;
        bit m;
        int n;
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_error = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);

        bd = {16'h0064, 16'hFFCE, 16'h0005}; be = {0, 0, 0};
        do_burst(MODE_INT, "int3");
        check("int3.const", obs_data, 64'h37);

        bd = {16'h3C00, 16'h4000}; be = {0, 0};
        do_burst(MODE_FP, "fp_add");
        check("fp_add.const", obs_data, 64'h4200);

        bd = {16'h3C00, 16'hBC00}; be = {0, 0};
        do_burst(MODE_FP, "fp_cancel");
        check("fp_cancel.const", obs_data, 64'h0);

        bd = {16'h7800, 16'h7800}; be = {0, 0};
        do_burst(MODE_FP, "fp_ovf");
        check("fp_ovf.const", obs_data, 64'h7BFF);

        // Back-pressure: result held while a new beat waits upstream.
        push(16'h0001, 1'b0, 1'b1, MODE_INT, w);
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", 64'(bus.out_valid), 64'd1);
            check("bp.data",  64'(bus.out_data),  64'd1);
            check("bp.ready", 64'(bus.in_ready),  64'd0);
            if (i == 2) begin
                bus.in_valid = 1'b1; bus.in_data = 16'h0007;
                bus.in_last = 1'b1; bus.mode = MODE_INT;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp.release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check("bp.held_beat", 64'(bus.out_data),  64'd7);
        check("bp.held_cnt",  64'(bus.out_count), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        bd = {16'h0003, 16'h0004}; be = {0, 1};
        do_burst(MODE_INT, "in_err");

        bd = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF}; be = {0, 0, 0, 0};
        do_burst(MODE_INT, "sat_pos");
        bd = {16'h8000, 16'h8000, 16'h8000, 16'h0001}; be = {0, 0, 0, 0};
        do_burst(MODE_INT, "sat_neg");

        bd.delete(); be.delete();
        for (int i = 0; i < 9; i++) begin bd.push_back(16'h0001); be.push_back(0); end
        do_burst(MODE_INT, "cnt_sat");

        // Reset in the middle of an INT burst drops it entirely.
        push(16'h0010, 1'b0, 1'b0, MODE_INT, w);
        push(16'h0020, 1'b1, 1'b0, MODE_INT, w);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        bd = {16'h0002}; be = {0};
        do_burst(MODE_INT, "after_rst");
        check("after_rst.const", obs_data, 64'h2);

        repeat (40) begin
            m = 1'($urandom);
            n = $urandom_range(1, 5);
            bd.delete(); be.delete();
            for (int i = 0; i < n; i++) begin
                bd.push_back(16'($urandom));
                be.push_back($urandom_range(0, 9) == 0);
            end
            do_burst(m, m ? "rnd_fp" : "rnd_int");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
